note_lane_renderer: RTL

NOTE_LANE_RENDERER -- requirements
Module: note_lane_renderer

---
 rtl/note_render_pkg.sv | 41 ++++
 rtl/note_lane_lut.sv | 42 ++++
 rtl/note_lane_renderer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/note_render_pkg.sv
// note_render_pkg -- shared types and constants for the note lane renderer.
//   state_t       : renderer FSM states
//   NOTE_*        : 4-bit note codes held in score_data[7:4] (rest = 0 .. B = 12)
//   LANE_Y*       : top y of each of the four note lanes; bars are BAR_H tall
//   COL_*         : 12-bit colours, dark/base/light for each lane
package note_render_pkg;

  typedef enum logic [2:0] {
    IDLE, ERASE, SAMPLE, ISSUE, WAIT_FIN, WAIT_REL
  } state_t;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_CS   = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_DS   = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_FS   = 4'd7;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_GS   = 4'd9;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_AS   = 4'd11;
  localparam logic [3:0] NOTE_B    = 4'd12;

  localparam logic [8:0] LANE_Y0 = 9'd150;  // C D E F
  localparam logic [8:0] LANE_Y1 = 9'd234;  // C# D# F#
  localparam logic [8:0] LANE_Y2 = 9'd318;  // G A B
  localparam logic [8:0] LANE_Y3 = 9'd402;  // G# A#
  localparam int         BAR_H   = 15;

  localparam logic [3:0]  OP_RECT      = 4'd0;
  localparam logic [8:0]  SCREEN_BOT_Y = 9'd479;
  localparam logic [11:0] ERASE_COLOR  = 12'hFFF;

  localparam logic [11:0] COL_L0_DK = 12'h639, COL_L0 = 12'hC9F, COL_L0_LT = 12'hECF;
  localparam logic [11:0] COL_L1_DK = 12'h063, COL_L1 = 12'h0C6, COL_L1_LT = 12'h9FC;
  localparam logic [11:0] COL_L2_DK = 12'h630, COL_L2 = 12'hF90, COL_L2_LT = 12'hFC9;
  localparam logic [11:0] COL_L3_DK = 12'h036, COL_L3 = 12'h09F, COL_L3_LT = 12'h9CF;

endpackage

// File: rtl/note_lane_lut.sv
// note_lane_lut -- combinational lane / colour lookup for one note.
//   i_note, i_octave : note code and octave of the score entry
//   i_keypad_octave  : octave selected on the keypad
//   o_tl_y, o_br_y   : vertical extent of the lane bar
//   o_color          : base colour on matching octave, dark below, light above
module note_lane_lut
  import note_render_pkg::*;
(
  input  logic [3:0]  i_note,
  input  logic [3:0]  i_octave,
  input  logic [3:0]  i_keypad_octave,
  output logic [8:0]  o_tl_y,
  output logic [8:0]  o_br_y,
  output logic [11:0] o_color
);

  logic [11:0] w_dk, w_base, w_lt;

  always_comb begin
    o_tl_y = LANE_Y0;
    w_dk   = COL_L0_DK;
    w_base = COL_L0;
    w_lt   = COL_L0_LT;
    case (i_note)
      NOTE_CS, NOTE_DS, NOTE_FS: begin
        o_tl_y = LANE_Y1; w_dk = COL_L1_DK; w_base = COL_L1; w_lt = COL_L1_LT;
      end
      NOTE_G, NOTE_A, NOTE_B: begin
        o_tl_y = LANE_Y2; w_dk = COL_L2_DK; w_base = COL_L2; w_lt = COL_L2_LT;
      end
      NOTE_GS, NOTE_AS: begin
        o_tl_y = LANE_Y3; w_dk = COL_L3_DK; w_base = COL_L3; w_lt = COL_L3_LT;
      end
      default: ;
    endcase
    o_br_y = o_tl_y + 9'(BAR_H - 1);
    if (i_octave == i_keypad_octave)     o_color = w_base;
    else if (i_octave < i_keypad_octave) o_color = w_dk;
    else                                 o_color = w_lt;
  end

endmodule

// File: rtl/note_lane_renderer.sv
// note_lane_renderer -- periodically repaints the note area as a row of
// lane bars, one per score entry starting at the note currently sounding.
//   en, REPAINT_CYCLES    : repaint cadence (counter runs only while idle)
//   note_pointer,
//   cur_note_length       : sampled once per frame for the first bar
//   keypad_octave         : selects base/dark/light shading
//   score_addr/score_data : combinational score ROM {length, note, octave}
//   gp_*                  : rectangle command, held with gp_en until gp_finish
//   frame_done            : one-cycle pulse when a frame has been drawn
module note_lane_renderer
  import note_render_pkg::*;
#(
  parameter int SCREEN_W       = 640,
  parameter int ORIGIN_X       = 351,
  parameter int LEN_SHIFT      = 2,
  parameter int ADDR_W         = 8,
  parameter int REPAINT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] note_pointer,
  input  logic [15:0]       cur_note_length,
  input  logic [3:0]        keypad_octave,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [23:0]       score_data,
  output logic              gp_en,
  output logic [3:0]        gp_opcode,
  output logic [9:0]        gp_tl_x,
  output logic [8:0]        gp_tl_y,
  output logic [9:0]        gp_br_x,
  output logic [8:0]        gp_br_y,
  output logic [11:0]       gp_arg,
  input  logic              gp_finish,
  output logic              frame_done
);

  localparam int CNT_W = (REPAINT_CYCLES > 1) ? $clog2(REPAINT_CYCLES) : 1;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_len_s;
  logic [10:0]       r_x;
  logic              r_first, r_sampled, r_last, r_frame_done;
  logic [3:0]        r_opcode;
  logic [9:0]        r_tl_x, r_br_x;
  logic [8:0]        r_tl_y, r_br_y;
  logic [11:0]       r_arg;

  logic        w_ld_erase, w_ld_bar, w_sample, w_adv, w_done;
  logic [15:0] w_len, w_wfull;
  logic [10:0] w_w, w_sum, w_xn, w_brx;
  logic        w_xover, w_endmk, w_skip, w_wrap;
  logic [8:0]  w_tl_y, w_br_y;
  logic [11:0] w_color;

  // First bar uses the sampled remaining length; later bars use the score.
  assign w_len   = r_first ? r_len_s : score_data[23:8];
  assign w_wfull = w_len >> LEN_SHIFT;
  // Saturate width to 10 bits so x + width fits 11 bits without wrapping.
  assign w_w     = (|w_wfull[15:10]) ? 11'h3FF : {1'b0, w_wfull[9:0]};
  assign w_sum   = r_x + w_w;
  assign w_xn    = (w_sum > 11'(SCREEN_W)) ? 11'(SCREEN_W) : w_sum;
  assign w_brx   = w_xn - 11'd1;
  assign w_xover = r_x > 11'(SCREEN_W - 1);
  assign w_endmk = !r_first && (score_data[23:8] == 16'd0);
  assign w_skip  = (score_data[7:4] == NOTE_REST) || (w_w == 11'd0);
  assign w_wrap  = &r_idx;

  note_lane_lut u_lut (
    .i_note          (score_data[7:4]),
    .i_octave        (score_data[3:0]),
    .i_keypad_octave (keypad_octave),
    .o_tl_y          (w_tl_y),
    .o_br_y          (w_br_y),
    .o_color         (w_color)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ld_erase = 1'b0;
    w_ld_bar   = 1'b0;
    w_sample   = 1'b0;
    w_adv      = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE:
        if (en && r_cnt == CNT_W'(REPAINT_CYCLES - 1)) begin
          w_next     = ERASE;
          w_ld_erase = 1'b1;
        end
      ERASE:
        if (gp_finish) w_next = WAIT_REL;
      SAMPLE: begin
        w_sample = 1'b1;
        w_next   = ISSUE;
      end
      ISSUE:
        if (w_xover || w_endmk) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else begin
          w_adv = 1'b1;
          if (!w_skip) begin
            w_ld_bar = 1'b1;
            w_next   = WAIT_FIN;
          end else if (w_wrap) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end
      WAIT_FIN:
        if (gp_finish) w_next = WAIT_REL;
      WAIT_REL:
        if (!gp_finish) begin
          // The erase is the only command issued before sampling.
          if (!r_sampled) w_next = SAMPLE;
          else if (r_last) begin
            w_done = 1'b1;
            w_next = IDLE;
          end else w_next = ISSUE;
        end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_len_s      <= '0;
      r_x          <= '0;
      r_first      <= 1'b0;
      r_sampled    <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_opcode     <= '0;
      r_tl_x       <= '0;
      r_tl_y       <= '0;
      r_br_x       <= '0;
      r_br_y       <= '0;
      r_arg        <= '0;
    end else begin
      r_frame_done <= w_done;
      r_cnt <= (r_state == IDLE && en && !w_ld_erase) ? r_cnt + 1'b1 : '0;
      if (w_ld_erase) begin
        r_sampled <= 1'b0;
        r_opcode  <= OP_RECT;
        r_tl_x    <= 10'(ORIGIN_X);
        r_tl_y    <= '0;
        r_br_x    <= 10'(SCREEN_W - 1);
        r_br_y    <= SCREEN_BOT_Y;
        r_arg     <= ERASE_COLOR;
      end
      if (w_sample) begin
        r_idx     <= note_pointer;
        r_len_s   <= cur_note_length;
        r_x       <= 11'(ORIGIN_X);
        r_first   <= 1'b1;
        r_sampled <= 1'b1;
      end
      if (w_adv) begin
        r_x     <= w_xn;
        r_idx   <= r_idx + 1'b1;
        r_first <= 1'b0;
        r_last  <= w_wrap;
      end
      if (w_ld_bar) begin
        r_opcode <= OP_RECT;
        r_tl_x   <= r_x[9:0];
        r_tl_y   <= w_tl_y;
        r_br_x   <= w_brx[9:0];
        r_br_y   <= w_br_y;
        r_arg    <= w_color;
      end
    end
  end

  assign gp_en      = (r_state == ERASE) || (r_state == WAIT_FIN);
  assign score_addr = r_idx;
  assign gp_opcode  = r_opcode;
  assign gp_tl_x    = r_tl_x;
  assign gp_tl_y    = r_tl_y;
  assign gp_br_x    = r_br_x;
  assign gp_br_y    = r_br_y;
  assign gp_arg     = r_arg;
  assign frame_done = r_frame_done;

endmodule
